// File: rtl/lisnoc_packetizer.sv
// -----------------------------------------------------------------------------
// lisnoc_packetizer
//
// Turns a packet request (destination, payload length, virtual channel) plus
// a stream of 32-bit payload words into LISNoC flits for one mesh link.
// A header flit is sent first, then one flit per payload word with the final
// word typed "last". A zero-length request produces a single flit of type
// "single" that carries the header content and consumes no data words.
//
// Flit layout: {type[1:0], content[31:0]}
//   type 2'b01 header, 2'b00 payload, 2'b10 last, 2'b11 single
//   header content = {dest[4:0], 3'b000, len[7:0], 16'h0000}
//
// Parameters / macros
//   vchannels                 number of virtual channels on the link
//   FLIT_WIDTH (macro)        flit width, 34 unless defined beforehand
//   LISNOC_PACKETIZER_CNT_EN  when defined, adds pkt_count_o, a 16-bit
//                             wrapping count of transferred last/single flits
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   pkt_start_i/_ready_o, pkt_dest_i, pkt_len_i, pkt_vc_i
//                       packet request handshake and its attributes
//   data_i, data_valid_i, data_ready_o
//                       payload word handshake
//   link_flit_o, link_valid_o, link_ready_i
//                       outgoing flit with per-VC valid/ready
//   pkt_count_o         (optional) completed packet count
// -----------------------------------------------------------------------------
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 34
`endif

module lisnoc_packetizer #(
    parameter int vchannels = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pkt_start_i,
    input  logic [4:0]             pkt_dest_i,
    input  logic [7:0]             pkt_len_i,
    input  logic [vchannels-1:0]   pkt_vc_i,
    output logic                   pkt_start_ready_o,
    input  logic [31:0]            data_i,
    input  logic                   data_valid_i,
    output logic                   data_ready_o,
    output logic [`FLIT_WIDTH-1:0] link_flit_o,
    output logic [vchannels-1:0]   link_valid_o,
    input  logic [vchannels-1:0]   link_ready_i
`ifdef LISNOC_PACKETIZER_CNT_EN
    ,
    output logic [15:0]            pkt_count_o
`endif
);

    localparam int FW = `FLIT_WIDTH;

    localparam logic [1:0] TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] TYPE_HEADER  = 2'b01;
    localparam logic [1:0] TYPE_LAST    = 2'b10;
    localparam logic [1:0] TYPE_SINGLE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [4:0]             dest_q, dest_d;
    logic [7:0]             len_q, len_d;
    logic [vchannels-1:0]   vc_q, vc_d;
    logic [7:0]             cnt_q, cnt_d;

    // One-entry output register. The VC travels with the flit so that a new
    // request latched while the previous flit still waits cannot disturb it.
    logic                   out_valid_q, out_valid_d;
    logic [FW-1:0]          out_flit_q, out_flit_d;
    logic [vchannels-1:0]   out_vc_q, out_vc_d;

    logic                   xfer;
    logic                   can_load;
    logic [vchannels-1:0]   vc_onehot;

    function automatic logic [31:0] header_content(input logic [4:0] dest,
                                                   input logic [7:0] len);
        return {dest, 3'b000, len, 16'h0000};
    endfunction

    // Reduce the requested VC to exactly one bit: lowest set bit wins, and an
    // all-zero request falls back to VC 0.
    always_comb begin
        logic found;
        vc_onehot = '0;
        found     = 1'b0;
        for (int i = 0; i < vchannels; i++) begin
            if (pkt_vc_i[i] && !found) begin
                vc_onehot[i] = 1'b1;
                found        = 1'b1;
            end
        end
        if (!found) begin
            vc_onehot[0] = 1'b1;
        end
    end

    assign xfer     = out_valid_q & (|(out_vc_q & link_ready_i));
    assign can_load = ~out_valid_q | xfer;

    assign pkt_start_ready_o = (state_q == IDLE);
    assign data_ready_o      = (state_q == PAYLOAD) & can_load;
    assign link_flit_o       = out_flit_q;
    assign link_valid_o      = out_valid_q ? out_vc_q : '0;

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        len_d       = len_q;
        vc_d        = vc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        out_vc_d    = out_vc_q;

        if (xfer) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pkt_start_i) begin
                    dest_d = pkt_dest_i;
                    len_d  = pkt_len_i;
                    vc_d   = vc_onehot;
                    cnt_d  = pkt_len_i;
                    // The header is loaded on the handshake edge itself when
                    // the output register is free, so it is visible on the
                    // very next cycle; otherwise it waits in HEADER.
                    if (can_load) begin
                        out_valid_d = 1'b1;
                        out_vc_d    = vc_onehot;
                        out_flit_d  = {(pkt_len_i == 8'd0) ? TYPE_SINGLE : TYPE_HEADER,
                                       header_content(pkt_dest_i, pkt_len_i)};
                        state_d     = (pkt_len_i == 8'd0) ? IDLE : PAYLOAD;
                    end else begin
                        state_d = HEADER;
                    end
                end
            end

            HEADER: begin
                if (can_load) begin
                    out_valid_d = 1'b1;
                    out_vc_d    = vc_q;
                    out_flit_d  = {(len_q == 8'd0) ? TYPE_SINGLE : TYPE_HEADER,
                                   header_content(dest_q, len_q)};
                    state_d     = (len_q == 8'd0) ? IDLE : PAYLOAD;
                end
            end

            PAYLOAD: begin
                if (data_valid_i && can_load) begin
                    out_valid_d = 1'b1;
                    out_vc_d    = vc_q;
                    out_flit_d  = {(cnt_q == 8'd1) ? TYPE_LAST : TYPE_PAYLOAD, data_i};
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                    if (cnt_q <= 8'd1) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            len_q       <= '0;
            vc_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_vc_q    <= '0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            len_q       <= len_d;
            vc_q        <= vc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_vc_q    <= out_vc_d;
        end
    end

`ifdef LISNOC_PACKETIZER_CNT_EN
    // Type bit 1 is set for both "last" and "single": one per finished packet.
    logic [15:0] pkt_count_q, pkt_count_d;

    assign pkt_count_d = (xfer && out_flit_q[FW-1]) ? pkt_count_q + 16'd1 : pkt_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count_o = pkt_count_q;
`endif

endmodule

// File: tb/tb_lisnoc_packetizer.sv
// -----------------------------------------------------------------------------
// Testbench for lisnoc_packetizer (two virtual channels).
// A packet-level model turns every accepted request and payload word into the
// flits the link must carry, in order; each cycle the model checks the link
// against that expectation. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_lisnoc_packetizer;

    localparam int VCH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            pkt_start_i;
    logic [4:0]      pkt_dest_i;
    logic [7:0]      pkt_len_i;
    logic [VCH-1:0]  pkt_vc_i;
    logic            pkt_start_ready_o;
    logic [31:0]     data_i;
    logic            data_valid_i;
    logic            data_ready_o;
    logic [33:0]     link_flit_o;
    logic [VCH-1:0]  link_valid_o;
    logic [VCH-1:0]  link_ready_i;
`ifdef LISNOC_PACKETIZER_CNT_EN
    logic [15:0]     pkt_count_o;
`endif

    lisnoc_packetizer #(.vchannels(VCH)) dut (
        .clk               (clk),
        .rst               (rst),
        .pkt_start_i       (pkt_start_i),
        .pkt_dest_i        (pkt_dest_i),
        .pkt_len_i         (pkt_len_i),
        .pkt_vc_i          (pkt_vc_i),
        .pkt_start_ready_o (pkt_start_ready_o),
        .data_i            (data_i),
        .data_valid_i      (data_valid_i),
        .data_ready_o      (data_ready_o),
        .link_flit_o       (link_flit_o),
        .link_valid_o      (link_valid_o),
        .link_ready_i      (link_ready_i)
`ifdef LISNOC_PACKETIZER_CNT_EN
        ,
        .pkt_count_o       (pkt_count_o)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Packet-level model state
    logic [33:0]    exp_flit_q[$];
    logic [VCH-1:0] exp_vc_q[$];
    int             mdl_rem  = 0;
    logic [VCH-1:0] mdl_vc   = '0;
    int             mdl_pkts = 0;
    bit             held     = 1'b0;
    logic [33:0]    held_flit;
    logic [VCH-1:0] held_lv;
    bit             data_acc = 1'b0;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VCH-1:0] pick_vc(input logic [VCH-1:0] v);
        logic [VCH-1:0] r;
        r = '0;
        for (int i = 0; i < VCH; i++) begin
            if (v[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        r[0] = 1'b1;
        return r;
    endfunction

    // Called once per cycle at the falling edge: compare, then absorb inputs.
    task automatic model_step();
        data_acc = 1'b0;
        if (rst) begin
            chk(link_valid_o == '0, "valid_in_reset", 64'(link_valid_o), 64'(0));
            exp_flit_q.delete();
            exp_vc_q.delete();
            mdl_rem  = 0;
            mdl_pkts = 0;
            held     = 1'b0;
            return;
        end
        if (held) begin
            chk(link_flit_o == held_flit && link_valid_o == held_lv, "hold_stable",
                64'({link_valid_o, link_flit_o}), 64'({held_lv, held_flit}));
        end
        if (mdl_rem != 0) begin
            chk(pkt_start_ready_o == 1'b0, "start_ready_busy", 64'(pkt_start_ready_o), 64'(0));
        end else begin
            chk(data_ready_o == 1'b0, "data_ready_idle", 64'(data_ready_o), 64'(0));
        end
`ifdef LISNOC_PACKETIZER_CNT_EN
        chk(pkt_count_o == 16'(mdl_pkts), "pkt_count", 64'(pkt_count_o), 64'(mdl_pkts));
`endif
        if (link_valid_o != '0) begin
            if (exp_flit_q.size() == 0) begin
                chk(1'b0, "spurious_flit", 64'(link_flit_o), 64'(0));
            end else begin
                chk(link_valid_o == exp_vc_q[0], "valid_vc", 64'(link_valid_o), 64'(exp_vc_q[0]));
                if ((link_valid_o & link_ready_i) != '0) begin
                    chk(link_flit_o == exp_flit_q[0], "flit", 64'(link_flit_o), 64'(exp_flit_q[0]));
                    $display("xfer flit=%h vc=%b", link_flit_o, link_valid_o);
                    if (exp_flit_q[0][33]) mdl_pkts++;
                    void'(exp_flit_q.pop_front());
                    void'(exp_vc_q.pop_front());
                end
            end
        end
        held      = (link_valid_o != '0) && ((link_valid_o & link_ready_i) == '0);
        held_flit = link_flit_o;
        held_lv   = link_valid_o;

        if (pkt_start_i && pkt_start_ready_o) begin
            mdl_vc  = pick_vc(pkt_vc_i);
            mdl_rem = int'(pkt_len_i);
            exp_flit_q.push_back({(pkt_len_i == 8'd0) ? 2'b11 : 2'b01,
                                  pkt_dest_i, 3'b000, pkt_len_i, 16'h0000});
            exp_vc_q.push_back(mdl_vc);
        end
        if (data_valid_i && data_ready_o && mdl_rem != 0) begin
            exp_flit_q.push_back({(mdl_rem == 1) ? 2'b10 : 2'b00, data_i});
            exp_vc_q.push_back(mdl_vc);
            mdl_rem--;
            data_acc = 1'b1;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt(input logic [4:0] d, input logic [7:0] l, input logic [VCH-1:0] v);
        pkt_start_i = 1'b1;
        pkt_dest_i  = d;
        pkt_len_i   = l;
        pkt_vc_i    = v;
        cyc();
        pkt_start_i = 1'b0;
    endtask

    initial begin
        int idx;
        rst          = 1'b1;
        pkt_start_i  = 1'b0;
        pkt_dest_i   = '0;
        pkt_len_i    = '0;
        pkt_vc_i     = '0;
        data_i       = '0;
        data_valid_i = 1'b0;
        link_ready_i = 2'b11;

        // Reset state
        repeat (3) cyc();
        chk(link_valid_o == '0, "rst_valid", 64'(link_valid_o), 64'(0));
        chk(link_flit_o == 34'h0, "rst_flit", 64'(link_flit_o), 64'(0));
        chk(data_ready_o == 1'b0, "rst_data_ready", 64'(data_ready_o), 64'(0));
        rst = 1'b0;
        cyc();
        chk(pkt_start_ready_o == 1'b1, "rst_start_ready", 64'(pkt_start_ready_o), 64'(1));

        // Reset pulse while idle
        rst = 1'b1;
        #1;
        chk(link_valid_o == '0, "idle_rst_valid", 64'(link_valid_o), 64'(0));
        cyc();
        rst = 1'b0;
        cyc();
        chk(pkt_start_ready_o == 1'b1, "idle_rst_start_ready", 64'(pkt_start_ready_o), 64'(1));

        // Zero-length packet: single flit on the next cycle
        start_pkt(5'd3, 8'd0, 2'b01);
        chk(link_flit_o == 34'h3_1800_0000, "single_flit", 64'(link_flit_o), 64'(34'h3_1800_0000));
        chk(link_valid_o == 2'b01, "single_valid", 64'(link_valid_o), 64'(2'b01));
        cyc();
        chk(link_valid_o == '0, "single_done", 64'(link_valid_o), 64'(0));
        chk(pkt_start_ready_o == 1'b1, "single_idle", 64'(pkt_start_ready_o), 64'(1));

        // Two-word packet at full throughput
        start_pkt(5'd2, 8'd2, 2'b01);
        chk(link_flit_o == 34'h1_1002_0000, "hdr_flit", 64'(link_flit_o), 64'(34'h1_1002_0000));
        chk(data_ready_o == 1'b1, "payload_ready", 64'(data_ready_o), 64'(1));
        data_i = 32'hA; data_valid_i = 1'b1;
        cyc();
        chk(link_flit_o == 34'h0_0000_000A, "pay_flit", 64'(link_flit_o), 64'(34'h0_0000_000A));
        data_i = 32'hB;
        cyc();
        chk(link_flit_o == 34'h2_0000_000B, "last_flit", 64'(link_flit_o), 64'(34'h2_0000_000B));
        data_valid_i = 1'b0;
        cyc();
        chk(link_valid_o == '0, "pkt2_done", 64'(link_valid_o), 64'(0));

        // Same packet with link back-pressure during payload
        start_pkt(5'd2, 8'd2, 2'b01);
        data_i = 32'hA; data_valid_i = 1'b1;
        cyc();
        data_i = 32'hB;
        for (int i = 0; i < 3; i++) begin
            link_ready_i = (i == 1) ? 2'b10 : 2'b00;
            cyc();
            chk(link_flit_o == 34'h0_0000_000A, "stall_flit", 64'(link_flit_o), 64'(34'h0_0000_000A));
            chk(link_valid_o == 2'b01, "stall_valid", 64'(link_valid_o), 64'(2'b01));
            chk(data_ready_o == 1'b0, "stall_data_ready", 64'(data_ready_o), 64'(0));
        end
        link_ready_i = 2'b11;
        cyc();
        chk(link_flit_o == 34'h2_0000_000B, "stall_last", 64'(link_flit_o), 64'(34'h2_0000_000B));
        data_valid_i = 1'b0;
        cyc();

        // Request accepted while previous single flit is blocked on VC1
        link_ready_i = 2'b01;
        start_pkt(5'd1, 8'd0, 2'b10);
        chk(link_flit_o == 34'h3_0800_0000, "vc1_single", 64'(link_flit_o), 64'(34'h3_0800_0000));
        chk(link_valid_o == 2'b10, "vc1_valid", 64'(link_valid_o), 64'(2'b10));
        start_pkt(5'd7, 8'd1, 2'b00);
        chk(link_flit_o == 34'h3_0800_0000, "blocked_hold", 64'(link_flit_o), 64'(34'h3_0800_0000));
        chk(pkt_start_ready_o == 1'b0, "header_wait_busy", 64'(pkt_start_ready_o), 64'(0));
        link_ready_i = 2'b11;
        cyc();
        chk(link_flit_o == 34'h1_3801_0000, "late_hdr", 64'(link_flit_o), 64'(34'h1_3801_0000));
        chk(link_valid_o == 2'b01, "vc0_default", 64'(link_valid_o), 64'(2'b01));
        data_i = 32'h55; data_valid_i = 1'b1;
        cyc();
        chk(link_flit_o == 34'h2_0000_0055, "late_last", 64'(link_flit_o), 64'(34'h2_0000_0055));
        data_valid_i = 1'b0;
        cyc();

        // Reset in the middle of a len=4 packet
        start_pkt(5'd4, 8'd4, 2'b01);
        data_i = 32'h1; data_valid_i = 1'b1;
        cyc();
        data_i = 32'h2;
        cyc();
        rst = 1'b1;
        #1;
        chk(link_valid_o == '0, "rst_mid_valid", 64'(link_valid_o), 64'(0));
        chk(link_flit_o == 34'h0, "rst_mid_flit", 64'(link_flit_o), 64'(0));
        data_valid_i = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        start_pkt(5'd5, 8'd1, 2'b01);
        chk(link_flit_o == 34'h1_2801_0000, "fresh_hdr", 64'(link_flit_o), 64'(34'h1_2801_0000));
        data_i = 32'h77; data_valid_i = 1'b1;
        cyc();
        chk(link_flit_o == 34'h2_0000_0077, "fresh_last", 64'(link_flit_o), 64'(34'h2_0000_0077));
        data_valid_i = 1'b0;
        cyc();

        // Streamed packet with data gaps and intermittent VC1 back-pressure
        start_pkt(5'd9, 8'd6, 2'b10);
        idx = 0;
        for (int c = 0; c < 100 && idx < 6; c++) begin
            data_valid_i = ((c % 3) != 2);
            data_i       = 32'hC000_0000 + 32'(idx);
            link_ready_i = ((c % 4) == 1) ? 2'b01 : 2'b11;
            cyc();
            if (data_acc) idx++;
        end
        if (idx < 6) chk(1'b0, "stream_budget", 64'(idx), 64'(6));
        data_valid_i = 1'b0;
        link_ready_i = 2'b11;
        repeat (4) cyc();
        chk(exp_flit_q.size() == 0, "drained", 64'(exp_flit_q.size()), 64'(0));

`ifdef LISNOC_PACKETIZER_CNT_EN
        // Three packets from reset -> count of 3
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        start_pkt(5'd1, 8'd0, 2'b01);
        start_pkt(5'd2, 8'd1, 2'b01);
        data_i = 32'h11; data_valid_i = 1'b1;
        cyc();
        data_valid_i = 1'b0;
        start_pkt(5'd3, 8'd2, 2'b01);
        data_i = 32'h21; data_valid_i = 1'b1;
        cyc();
        data_i = 32'h22;
        cyc();
        data_valid_i = 1'b0;
        repeat (3) cyc();
        chk(pkt_count_o == 16'd3, "count_three", 64'(pkt_count_o), 64'(3));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
